// File: rtl/ring_osc_pkg.sv
// rtl/ring_osc_pkg.sv - shared FSM encodings, default parameters and ring length helper
`timescale 1ns/1ps
package ring_osc_pkg;

   typedef logic [1:0] state_t;

   localparam state_t ST_IDLE    = 2'd0;
   localparam state_t ST_SETTLE  = 2'd1;
   localparam state_t ST_MEASURE = 2'd2;
   localparam state_t ST_DONE    = 2'd3;

   localparam int  DEF_NUM_TAPS       = 8;
   localparam int  DEF_BASE_LEN       = 1000;
   localparam int  DEF_STEP_LEN       = 100;
   localparam int  DEF_WINDOW_W       = 16;
   localparam int  DEF_COUNT_W        = 16;
   localparam int  DEF_SETTLE_CYC     = 16;
   localparam real DEF_STAGE_DELAY_NS = 0.05;

   // Inversions around the loop when tap k closes it: NAND + base chain + k step chains.
   function automatic int ring_stages(input int tap, input int base_len, input int step_len);
      return 1 + base_len + tap * step_len;
   endfunction

endpackage

// File: rtl/gated_tapped_ring.sv
// rtl/gated_tapped_ring.sv - NAND-gated inverter ring with selectable tap, purely combinational
// Even-length segments keep every tap at the parked level (1) while en_i is low.
`timescale 1ns/1ps
(* keep_hierarchy = "yes" *)
module gated_tapped_ring #(
   parameter int  NUM_TAPS       = 8,
   parameter int  BASE_LEN       = 1000,
   parameter int  STEP_LEN       = 100,
   parameter real STAGE_DELAY_NS = 0.05
) (
   input  logic                        en_i,
   input  logic [$clog2(NUM_TAPS)-1:0] sel_i,
   output logic                        tap_o
);

   logic                nand_w;
   logic [NUM_TAPS-1:0] tap_w;

`ifdef SYNTHESIS
   assign nand_w = ~(en_i & tap_o);
`else
   assign #(STAGE_DELAY_NS) nand_w = ~(en_i & tap_o);
`endif

   assign tap_o = tap_w[sel_i];

   for (genvar s = 0; s < NUM_TAPS; s++) begin : g_seg
      localparam int LEN = (s == 0) ? BASE_LEN : STEP_LEN;
      logic seg_in;
      logic seg_out;

      if (s == 0) begin : g_head
         assign seg_in = nand_w;
      end else begin : g_link
         assign seg_in = g_seg[s-1].seg_out;
      end

      for (genvar i = 0; i < LEN; i++) begin : g_inv
         (* keep *) logic n;
         if (i == 0) begin : g_first
            assign n = ~seg_in;
         end else begin : g_next
            assign n = ~g_inv[i-1].n;
         end
      end

      // Simulation delay lumped at the segment output: LEN stages worth.
`ifdef SYNTHESIS
      assign seg_out = g_inv[LEN-1].n;
`else
      assign #(STAGE_DELAY_NS * LEN) seg_out = g_inv[LEN-1].n;
`endif
      assign tap_w[s] = seg_out;
   end

endmodule

// File: rtl/ring_osc_meter.sv
// rtl/ring_osc_meter.sv - gated tapped ring oscillator with windowed edge-count frequency meter
// Optional RING_OSC_METER_AUTORUN_EN: back-to-back measurements while start is held.
`timescale 1ns/1ps
module ring_osc_meter
   import ring_osc_pkg::*;
#(
   parameter int  NUM_TAPS       = DEF_NUM_TAPS,
   parameter int  BASE_LEN       = DEF_BASE_LEN,
   parameter int  STEP_LEN       = DEF_STEP_LEN,
   parameter int  WINDOW_W       = DEF_WINDOW_W,
   parameter int  COUNT_W        = DEF_COUNT_W,
   parameter int  SETTLE_CYC     = DEF_SETTLE_CYC,
   parameter real STAGE_DELAY_NS = DEF_STAGE_DELAY_NS
) (
   input  logic                        clk,
   input  logic                        rst,
   input  logic                        start,
   input  logic                        abort,
   input  logic [$clog2(NUM_TAPS)-1:0] tap_sel,
   input  logic [WINDOW_W-1:0]         window_len,
   output logic                        busy,
   output logic                        done,
   output logic [COUNT_W-1:0]          count,
   output logic                        overflow,
   output logic                        osc_out
);

   localparam int                  TAP_W       = $clog2(NUM_TAPS);
   localparam logic [WINDOW_W-1:0] SETTLE_LAST = WINDOW_W'(SETTLE_CYC - 1);

   state_t              state_q, state_d;
   logic [TAP_W-1:0]    tap_q, tap_d;
   logic [WINDOW_W-1:0] win_len_q, win_len_d;
   logic [WINDOW_W-1:0] cyc_q, cyc_d;
   logic [COUNT_W-1:0]  cnt_q, cnt_d;
   logic                ovf_q, ovf_d;
   logic [COUNT_W-1:0]  count_q, count_d;
   logic                overflow_q, overflow_d;
   logic                ring_en_q, ring_en_d;
   logic                s1_q, s2_q, s3_q;
   logic                osc_w;
   logic                rise_w;
   logic [WINDOW_W-1:0] win_last_w;

   gated_tapped_ring #(
      .NUM_TAPS       (NUM_TAPS),
      .BASE_LEN       (BASE_LEN),
      .STEP_LEN       (STEP_LEN),
      .STAGE_DELAY_NS (STAGE_DELAY_NS)
   ) u_ring (
      .en_i  (ring_en_q),
      .sel_i (tap_q),
      .tap_o (osc_w)
   );

   assign rise_w     = s2_q & ~s3_q;
   // A zero window wraps to all-ones, giving 2^WINDOW_W measure cycles.
   assign win_last_w = win_len_q - WINDOW_W'(1);

   always_comb begin
      state_d    = state_q;
      tap_d      = tap_q;
      win_len_d  = win_len_q;
      cyc_d      = cyc_q + WINDOW_W'(1);
      cnt_d      = cnt_q;
      ovf_d      = ovf_q;
      count_d    = count_q;
      overflow_d = overflow_q;
      case (state_q)
         ST_IDLE: begin
            cyc_d = '0;
            cnt_d = '0;
            ovf_d = 1'b0;
            if (start) begin
               state_d   = ST_SETTLE;
               tap_d     = tap_sel;
               win_len_d = window_len;
            end
         end
         ST_SETTLE: begin
            cnt_d = '0;
            ovf_d = 1'b0;
            if (abort) begin
               state_d = ST_IDLE;
            end else if (cyc_q == SETTLE_LAST) begin
               state_d = ST_MEASURE;
               cyc_d   = '0;
            end
         end
         ST_MEASURE: begin
            if (rise_w) begin
               if (&cnt_q) begin
                  ovf_d = 1'b1;
               end else begin
                  cnt_d = cnt_q + COUNT_W'(1);
               end
            end
            if (abort) begin
               state_d = ST_IDLE;
            end else if (cyc_q == win_last_w) begin
               state_d    = ST_DONE;
               count_d    = cnt_d;
               overflow_d = ovf_d;
            end
         end
         default: begin
            cyc_d   = '0;
            cnt_d   = '0;
            ovf_d   = 1'b0;
            state_d = ST_IDLE;
`ifdef RING_OSC_METER_AUTORUN_EN
            if (start) begin
               tap_d     = tap_sel;
               win_len_d = window_len;
               // Same tap: ring is already stable, skip the settle phase.
               state_d   = (tap_sel == tap_q) ? ST_MEASURE : ST_SETTLE;
            end
`endif
         end
      endcase
   end

`ifdef RING_OSC_METER_AUTORUN_EN
   assign ring_en_d = (state_d == ST_SETTLE) || (state_d == ST_MEASURE) || (state_d == ST_DONE);
`else
   assign ring_en_d = (state_d == ST_SETTLE) || (state_d == ST_MEASURE);
`endif

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q    <= ST_IDLE;
         tap_q      <= '0;
         win_len_q  <= '0;
         cyc_q      <= '0;
         cnt_q      <= '0;
         ovf_q      <= 1'b0;
         count_q    <= '0;
         overflow_q <= 1'b0;
         ring_en_q  <= 1'b0;
         s1_q       <= 1'b0;
         s2_q       <= 1'b0;
         s3_q       <= 1'b0;
      end else begin
         state_q    <= state_d;
         tap_q      <= tap_d;
         win_len_q  <= win_len_d;
         cyc_q      <= cyc_d;
         cnt_q      <= cnt_d;
         ovf_q      <= ovf_d;
         count_q    <= count_d;
         overflow_q <= overflow_d;
         ring_en_q  <= ring_en_d;
         s1_q       <= osc_w;
         s2_q       <= s1_q;
         s3_q       <= s2_q;
      end
   end

   assign busy     = (state_q == ST_SETTLE) || (state_q == ST_MEASURE);
   assign done     = (state_q == ST_DONE);
   assign count    = count_q;
   assign overflow = overflow_q;
   assign osc_out  = osc_w;

endmodule

// File: tb/tb_ring_osc_meter.sv
// tb/tb_ring_osc_meter.sv - scoreboard bench for ring_osc_meter (10 ns clk, 50 ps stages)
`timescale 1ns/1ps
module tb_ring_osc_meter;

   localparam int BASE_LEN   = 1000;
   localparam int STEP_LEN   = 100;
   localparam int SETTLE_CYC = 16;

   typedef struct {
      longint cnt;
      longint tol;
      longint ovf;
      longint cyc;
   } exp_t;

   logic        clk = 1'b0;
   logic        rst;
   logic        start, start4, abort, abort4;
   logic [2:0]  tap_sel;
   logic [15:0] window_len;
   logic        busy, done, overflow, osc_out;
   logic [15:0] count;
   logic        busy4, done4, overflow4, osc4;
   logic [3:0]  count4;

   int     n_total = 0;
   int     n_bad   = 0;
   int     n_done  = 0;
   int     osc_toggles = 0;
   longint cyc = 0;
   exp_t   sb[$];
   exp_t   sb4[$];

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;
   always @(osc_out) osc_toggles++;

   ring_osc_meter #(.COUNT_W(16), .STAGE_DELAY_NS(0.05)) u_dut (
      .clk(clk), .rst(rst), .start(start), .abort(abort),
      .tap_sel(tap_sel), .window_len(window_len),
      .busy(busy), .done(done), .count(count), .overflow(overflow), .osc_out(osc_out)
   );

   ring_osc_meter #(.COUNT_W(4), .STAGE_DELAY_NS(0.05)) u_dut4 (
      .clk(clk), .rst(rst), .start(start4), .abort(abort4),
      .tap_sel(tap_sel), .window_len(window_len),
      .busy(busy4), .done(done4), .count(count4), .overflow(overflow4), .osc_out(osc4)
   );

   task automatic check_val(input string tag, input longint got, input longint exp, input longint tol);
      n_total++;
      if (got < exp - tol || got > exp + tol) begin
         n_bad++;
         $display("FAIL %s: got=%0d want=%0d tol=%0d (cycle %0d)", tag, got, exp, tol, cyc);
      end
   endtask

   // Ring period is 2 * (1 + BASE + k*STEP) * 50 ps; edges in W cycles of 10 ns, floored.
   function automatic exp_t model(input int tap, input int w, input int cw, input longint t0);
      exp_t   e;
      longint per_ps = 100 * (1 + BASE_LEN + tap * STEP_LEN);
      longint ideal  = (longint'(w) * 10000) / per_ps;
      longint maxv   = (longint'(1) << cw) - 1;
      e.cyc = t0 + SETTLE_CYC + w + 1;
      if (ideal > maxv) begin
         e.cnt = maxv; e.tol = 0; e.ovf = 1;
      end else begin
         e.cnt = ideal; e.tol = 1; e.ovf = 0;
      end
      return e;
   endfunction

   always @(negedge clk) begin
      exp_t e;
      if (done) begin
         n_done++;
         if (sb.size() == 0) begin
            check_val("done_unexpected", 1, 0, 0);
         end else begin
            e = sb.pop_front();
            check_val("done_cycle", cyc, e.cyc, 0);
            check_val("count", count, e.cnt, e.tol);
            check_val("overflow", overflow, e.ovf, 0);
            check_val("busy_in_done", busy, 0, 0);
         end
      end
      if (done4) begin
         n_done++;
         if (sb4.size() == 0) begin
            check_val("done4_unexpected", 1, 0, 0);
         end else begin
            e = sb4.pop_front();
            check_val("done4_cycle", cyc, e.cyc, 0);
            check_val("count4", count4, e.cnt, e.tol);
            check_val("overflow4", overflow4, e.ovf, 0);
         end
      end
   end

   task automatic kick(input int which, input int tap, input int w, input bit expect_done);
      @(negedge clk);
      tap_sel    = tap[2:0];
      window_len = w[15:0];
      if (which == 0) start = 1'b1;
      else            start4 = 1'b1;
      if (expect_done) begin
         if (which == 0) sb.push_back(model(tap, w, 16, cyc));
         else            sb4.push_back(model(tap, w, 4, cyc));
      end
      @(negedge clk);
      start  = 1'b0;
      start4 = 1'b0;
      check_val("busy_cycle1", (which == 0) ? busy : busy4, 1, 0);
   endtask

   task automatic wait_drain(input int budget);
      int n = 0;
      while ((sb.size() > 0 || sb4.size() > 0) && n < budget) begin
         @(negedge clk);
         n++;
      end
      if (sb.size() > 0 || sb4.size() > 0) begin
         check_val("done_timeout", sb.size() + sb4.size(), 0, 0);
         sb.delete();
         sb4.delete();
      end
   endtask

   initial begin
      #2ms;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      int t;
      int d0;
      longint t0;
      rst = 1'b1; start = 1'b0; start4 = 1'b0; abort = 1'b0; abort4 = 1'b0;
      tap_sel = '0; window_len = '0;

      repeat (10) @(negedge clk);
      t = osc_toggles;
      repeat (10) @(negedge clk);
      check_val("rst_busy", busy, 0, 0);
      check_val("rst_done", done, 0, 0);
      check_val("rst_count", count, 0, 0);
      check_val("rst_overflow", overflow, 0, 0);
      check_val("rst_count4", count4, 0, 0);
      check_val("rst_osc_static", osc_toggles - t, 0, 0);
      rst = 1'b0;

      kick(0, 0, 1000, 1'b1); wait_drain(1200);
      kick(0, 7, 1000, 1'b1); wait_drain(1200);
      kick(0, 0, 1000, 1'b1); wait_drain(1200);
      kick(0, 0, 1, 1'b1);    wait_drain(100);
      kick(0, 0, 1000, 1'b1); wait_drain(1200);
      kick(1, 0, 1000, 1'b1); wait_drain(1200);

      // Abort at MEASURE cycle 500: no done, previous tap-0 result retained.
      d0 = n_done;
      kick(0, 0, 1000, 1'b0);
      repeat (SETTLE_CYC + 500 - 1) @(negedge clk);
      abort = 1'b1;
      @(negedge clk);
      abort = 1'b0;
      check_val("abort_busy", busy, 0, 0);
      repeat (1100) @(negedge clk);
      check_val("abort_no_done", n_done - d0, 0, 0);
      check_val("abort_count_kept", count, 99, 1);
      check_val("parked_osc", osc_out, 1, 0);

      // Reset mid-run clears the result.
      kick(0, 0, 1000, 1'b0);
      repeat (SETTLE_CYC + 500 - 1) @(negedge clk);
      rst = 1'b1;
      @(negedge clk);
      check_val("rst_mid_busy", busy, 0, 0);
      check_val("rst_mid_count", count, 0, 0);
      check_val("rst_mid_overflow", overflow, 0, 0);
      rst = 1'b0;
      repeat (1100) @(negedge clk);
      check_val("rst_mid_no_done", n_done - d0, 0, 0);

      // Window 0 = 2^16; a second start with new settings mid-run is ignored.
      kick(0, 0, 65536, 1'b1);
      repeat (98) @(negedge clk);
      start = 1'b1; tap_sel = 3'd7; window_len = 16'd5;
      @(negedge clk);
      check_val("busy_restart", busy, 1, 0);
      start = 1'b0;
      d0 = n_done;
      wait_drain(66000);
      repeat (50) @(negedge clk);
      check_val("restart_single_done", n_done - d0, 1, 0);
      check_val("restart_idle", busy, 0, 0);

`ifdef RING_OSC_METER_AUTORUN_EN
      @(negedge clk);
      tap_sel = 3'd0; window_len = 16'd100; start = 1'b1;
      t0 = cyc;
      for (int k = 0; k < 3; k++) sb.push_back(model(0, 100, 16, t0 + k * 101));
      t = 0;
      while (sb.size() > 1 && t < 400) begin
         @(negedge clk);
         t++;
      end
      @(negedge clk);
      start = 1'b0;
      d0 = n_done;
      wait_drain(400);
      repeat (150) @(negedge clk);
      check_val("autorun_last_done", n_done - d0, 1, 0);
`else
      t0 = cyc;
`endif

      $display("test done: total=%0d bad=%0d", n_total, n_bad);
      $finish;
   end

endmodule

// File: doc/ring_osc_meter.md
# ring_osc_meter

Parametrised tapped ring oscillator with an on-chip frequency meter in the system clock domain. The ring has a NAND enable stage, `NUM_TAPS` selectable lengths and a synchronised edge counter. The counter measures ring rising edges over a programmable window of `clk` cycles. The ring runs only during a measurement. It is the characterisation successor to the free-running tapped ring and sits behind the project's register/IO wrapper.

## Interface
- `NUM_TAPS`, 8: selectable ring lengths (2..16).
- `BASE_LEN`, 1000: inverters before tap 0 (even).
- `STEP_LEN`, 100: inverters between successive taps (even).
- `WINDOW_W`, 16: width of window length.
- `COUNT_W`, 16: width of edge count.
- `SETTLE_CYC`, 16: settle cycles before counting (≥4).

- `clk`  in  1  system clock; single clock domain.
- `rst`  in  1  synchronous, active-high reset.
- `start`  in  1  request a measurement (level sampled).
- `abort`  in  1  cancel an in-flight measurement.
- `tap_sel`  in  $clog2(NUM_TAPS)  ring length select.
- `window_len`  in  WINDOW_W  measurement window in `clk` cycles; 0 means 2^WINDOW_W.
- `busy`  out  1  measurement in progress.
- `done`  out  1  one-cycle result-valid pulse.
- `count`  out  COUNT_W  last result; held until next `done`.
- `overflow`  out  1  last result saturated.
- `osc_out`  out  1  selected tap, raw and asynchronous, for the pad/scope.

## Operation
- Ring length for tap k: 1 NAND + `BASE_LEN` + k·`STEP_LEN` inversions. The total is odd, so the ring oscillates while NAND enable=1. When enable=0 the ring is parked.
- FSM states: IDLE, SETTLE, MEASURE, DONE.
- IDLE: ring disabled, `busy`=0. `start`=1 latches `tap_sel` and `window_len`, then the FSM goes to SETTLE.
- SETTLE: ring enabled. Counts `SETTLE_CYC` cycles, which flushes the synchroniser and the mux glitch, then goes to MEASURE. The edge counter is cleared.
- MEASURE: counts edges for exactly the latched window in cycles.
  - Edge = `s2 & ~s3`, where s1/s2/s3 is a 3-flop chain on the ring tap.
  - The counter saturates at all-ones and sets an internal overflow bit.
- DONE: one cycle.
  - `count` and `overflow` are loaded.
  - `done`=1.
  - Next state is IDLE.
- `start` while `busy` is ignored. Changes to `tap_sel`/`window_len` mid-measurement are ignored (they are latched at start).
- `abort`=1 in SETTLE or MEASURE: go to IDLE next cycle, ring disabled, no `done`, `count` unchanged. `abort` in IDLE or DONE has no effect.
- `rst` mid-operation: go to IDLE next cycle. Ring disabled, counters cleared.
- Accuracy: ±1 edge. Valid only if the ring period exceeds 2 `clk` periods. Faster rings under-count; detecting this is not required.

## Timing
- Reset values:
  - `busy`=0, `done`=0, `count`=0, `overflow`=0.
  - FSM=IDLE, ring disabled.
  - `osc_out` is static at its parked level.
- Start accepted in cycle 0 → `busy`=1 in cycle 1 (SETTLE).
- MEASURE spans cycles 1+`SETTLE_CYC` … `SETTLE_CYC`+W.
- `done`=1 in cycle `SETTLE_CYC`+W+1. `busy` is 0 in that cycle.
- Earliest next accepted start: cycle `SETTLE_CYC`+W+2.
- `count` updates in the same cycle `done` rises.

## Configuration
- `RING_OSC_METER_AUTORUN_EN` defined: from DONE, if `start`=1 the FSM goes straight to MEASURE with the ring kept running and no settle. `done` then pulses every W+1 cycles while `start` stays high. `tap_sel`/`window_len` are re-latched at each DONE; a tap change still routes via SETTLE.
- Macro undefined: DONE always goes to IDLE (one-shot per start).

## Structure
- Shared package `ring_osc_pkg`: FSM state enum, default parameter constants, and a function giving stage count per tap.
- Sub-module `gated_tapped_ring`: NAND enable stage, `keep_hierarchy` inverter segments and tap mux. It is purely combinational and carries a simulation-only per-stage delay (ignored by synthesis).
- FSM, synchroniser and counters live in the top module.

## Test plan
Bench setup: `clk` 10 ns, stage delay 50 ps.
- Tap 0, W=1000 → `done` at cycle 1017, `count`=99±1 (period ≈100.1 ns).
- Tap 7, W=1000 → `count`=58±1. Then tap 0 immediately after → 99±1.
- `COUNT_W`=4, tap 0, W=1000 → `count`=15, `overflow`=1.
- `abort` at cycle 500 of MEASURE → `busy`=0 next cycle, no `done`, `count` retains the previous result. Same check for `rst` mid-run, except outputs clear to 0.
- `start` re-asserted while `busy` and `window_len`=0 on a run with W=2^16 → the second start is ignored, and `done` comes at cycle 16+65536+1.
- AUTORUN_EN, `start` held high, W=100 → `done` pulses every 101 cycles, `count`≈10 each.
